// File: rtl/uart_tx_if.sv
// FIFO-side read handshake between the TX FIFO and the UART transmitter.
// The transmitter is the master: it issues read strobes and consumes data.
interface uart_tx_if;
  logic       FfEmpty;
  logic       FfRdEn;
  logic [7:0] FfData;

  modport master (input FfEmpty, input FfData, output FfRdEn);
  modport slave  (output FfEmpty, output FfData, input FfRdEn);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: pulls one byte per frame from the TX FIFO and shifts it
// out on tx as start + 8 data + STOP_BITS stop bits.
module uart_tx #(
  parameter int   BAUD_CYCLE = 868,
  parameter logic LSB_FIRST  = 1'b1,
  parameter int   STOP_BITS  = 1
) (
  input  logic clk,
  input  logic rstB,
  uart_tx_if.master ff,
  output logic tx,
  output logic busy,
  output logic txDone
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } stateT;

  localparam logic [9:0] BAUD_LAST = 10'(BAUD_CYCLE - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  stateT      stateReg, stateNext;
  logic [9:0] baudReg, baudNext;
  logic [2:0] bitReg, bitNext;
  logic [7:0] shiftReg, shiftNext;
  logic       txReg, txNext;
  logic       rdEn;
  logic       doneNext;
  logic       baudEnd;
  logic [7:0] dataOrdered;

  // Store the byte in transmit order so DATA always sends shiftReg[bitReg].
  for (genvar gi = 0; gi < 8; gi++) begin : gOrder
    assign dataOrdered[gi] = LSB_FIRST ? ff.FfData[gi] : ff.FfData[7-gi];
  end

  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      stateReg <= IDLE;
      baudReg  <= '0;
      bitReg   <= '0;
      shiftReg <= '0;
      txReg    <= 1'b1;
    end else begin
      stateReg <= stateNext;
      baudReg  <= baudNext;
      bitReg   <= bitNext;
      shiftReg <= shiftNext;
      txReg    <= txNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    baudNext  = baudReg;
    bitNext   = bitReg;
    shiftNext = shiftReg;
    txNext    = 1'b1;
    rdEn      = 1'b0;
    doneNext  = 1'b0;
    baudEnd   = (baudReg == BAUD_LAST);

    case (stateReg)
      IDLE: begin
        baudNext = '0;
        bitNext  = '0;
        if (!ff.FfEmpty) begin
          rdEn      = 1'b1;
          stateNext = LOAD;
        end
      end
      LOAD: begin
        baudNext  = '0;
        bitNext   = '0;
        shiftNext = dataOrdered;
        stateNext = START;
      end
      START: begin
        baudNext = baudEnd ? 10'd0 : baudReg + 10'd1;
        if (baudEnd) stateNext = DATA;
      end
      DATA: begin
        baudNext = baudEnd ? 10'd0 : baudReg + 10'd1;
        if (baudEnd) begin
          if (bitReg == 3'd7) begin
            bitNext   = '0;
            stateNext = STOP;
          end else begin
            bitNext = bitReg + 3'd1;
          end
        end
      end
      STOP: begin
        baudNext = baudEnd ? 10'd0 : baudReg + 10'd1;
        doneNext = baudEnd && (bitReg == STOP_LAST);
        if (baudEnd) begin
          if (bitReg == STOP_LAST) begin
            bitNext   = '0;
            stateNext = IDLE;
          end else begin
            bitNext = bitReg + 3'd1;
          end
        end
      end
      default: begin
        stateNext = IDLE;
        baudNext  = '0;
        bitNext   = '0;
      end
    endcase

    // The line flop takes the level of the state being entered, so tx
    // changes on the same edge as the state register.
    case (stateNext)
      START:   txNext = 1'b0;
      DATA:    txNext = shiftNext[bitNext];
      default: txNext = 1'b1;
    endcase
  end

  assign ff.FfRdEn = rdEn;
  assign tx        = txReg;
  assign busy      = (stateReg != IDLE) || rdEn;
  assign txDone    = doneNext;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three transmitters with different bit order / stop bit
// settings, FIFO models, and a line monitor checking frames against a queue.
module tb_uart_tx;

  localparam int BC = 16;
  localparam int NU = 3;
  localparam bit LSB_CFG  [NU] = '{1'b1, 1'b0, 1'b1};
  localparam int STOP_CFG [NU] = '{1, 1, 2};

  logic clk = 1'b0;
  logic rstB;
  always #5 clk = ~clk;

  logic [2:0] rdEnW, txW, busyW, doneW;
  logic [7:0] dataV [NU];

  // FIFO contents (written by stimulus) and read side (written by the FIFO model)
  logic [7:0]  fifoMem [NU][64];
  int          wrCnt [NU] = '{0, 0, 0};
  int          rdCnt [NU] = '{0, 0, 0};
  int          rdEnCnt [NU] = '{0, 0, 0};
  int          rdEnTime [NU][64];
  int          cycleNum = 0;

  // Scoreboard: expected line levels per frame, bit 0 = start bit
  logic [11:0] expMem [NU][64];
  int          expWr [NU] = '{0, 0, 0};
  int          expRd [NU] = '{0, 0, 0};

  int checkCnt = 0;
  int passCnt  = 0;

  for (genvar gi = 0; gi < NU; gi++) begin : gUnit
    uart_tx_if ffIf ();
    assign ffIf.FfEmpty = (rdCnt[gi] == wrCnt[gi]);
    assign ffIf.FfData  = dataV[gi];
    assign rdEnW[gi]    = ffIf.FfRdEn;

    uart_tx #(
      .BAUD_CYCLE (BC),
      .LSB_FIRST  (LSB_CFG[gi]),
      .STOP_BITS  (STOP_CFG[gi])
    ) dut (
      .clk    (clk),
      .rstB   (rstB),
      .ff     (ffIf.master),
      .tx     (txW[gi]),
      .busy   (busyW[gi]),
      .txDone (doneW[gi])
    );
  end

  always @(posedge clk) begin
    cycleNum <= cycleNum + 1;
    for (int u = 0; u < NU; u++) begin
      if (rdEnW[u]) begin
        dataV[u] <= fifoMem[u][rdCnt[u] & 63];
        if (rdCnt[u] != wrCnt[u]) rdCnt[u] <= rdCnt[u] + 1;
        rdEnTime[u][rdEnCnt[u] & 63] <= cycleNum;
        rdEnCnt[u] <= rdEnCnt[u] + 1;
      end
    end
  end

  function automatic logic [11:0] refFrame(logic [7:0] b, bit lsb);
    logic [11:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++)
      f[i+1] = lsb ? ((b >> i) & 8'd1) != 0 : ((b >> (7 - i)) & 8'd1) != 0;
    return f;
  endfunction

  task automatic check(input bit ok, input string name, input int act, input int req);
    checkCnt++;
    if (ok) passCnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic pushByte(input int u, input logic [7:0] b);
    fifoMem[u][wrCnt[u] & 63] = b;
    expMem[u][expWr[u] & 63]  = refFrame(b, LSB_CFG[u]);
    expWr[u]++;
    wrCnt[u]++;
    $display("push   unit%0d byte=%02h", u, b);
  endtask

  // Line monitor state
  bit          active [NU];
  int          cyc    [NU];
  bit          bitOk  [NU];
  bit          doneErr[NU];
  bit          busyErr[NU];
  logic [11:0] curFrame [NU];

  task automatic monStep();
    for (int u = 0; u < NU; u++) begin
      int nb = 9 + STOP_CFG[u];
      int bi;
      if (!rstB) begin
        active[u] = 1'b0;
        continue;
      end
      if (!active[u]) begin
        if (txW[u] == 1'b0) begin
          if (expRd[u] == expWr[u]) begin
            check(1'b0, $sformatf("unit%0d unexpected start bit", u), expRd[u], expWr[u] - 1);
            curFrame[u] = '1;
          end else begin
            curFrame[u] = expMem[u][expRd[u] & 63];
            expRd[u]++;
          end
          active[u]  = 1'b1;
          cyc[u]     = 0;
          bitOk[u]   = 1'b1;
          doneErr[u] = 1'b0;
          busyErr[u] = 1'b0;
        end else if (doneW[u]) begin
          check(1'b0, $sformatf("unit%0d txDone outside frame", u), 1, 0);
        end
      end
      if (active[u]) begin
        bi = cyc[u] / BC;
        if (txW[u] !== curFrame[u][bi]) bitOk[u] = 1'b0;
        if (doneW[u] !== (cyc[u] == nb * BC - 1)) doneErr[u] = 1'b1;
        if (busyW[u] !== 1'b1) busyErr[u] = 1'b1;
        if (cyc[u] % BC == BC - 1) begin
          check(bitOk[u], $sformatf("unit%0d frame%0d bit%0d level", u, expRd[u] - 1, bi),
                int'(txW[u]), int'(curFrame[u][bi]));
          bitOk[u] = 1'b1;
        end
        if (cyc[u] == nb * BC - 1) begin
          check(!doneErr[u], $sformatf("unit%0d txDone timing", u), int'(doneErr[u]), 0);
          check(!busyErr[u], $sformatf("unit%0d busy during frame", u), int'(busyErr[u]), 0);
          $display("frame  unit%0d levels=%03h", u, curFrame[u]);
          active[u] = 1'b0;
        end else begin
          cyc[u]++;
        end
      end
    end
  endtask

  function automatic bit allIdle();
    bit idle = (busyW == 3'b000);
    for (int u = 0; u < NU; u++)
      if (rdCnt[u] != wrCnt[u]) idle = 1'b0;
    return idle;
  endfunction

  task automatic waitIdle(input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!allIdle() && n < limit);
    check(n < limit, "wait for idle within budget", n, limit);
  endtask

  task automatic runStim();
    bit ok;
    int n;
    int base;

    // Reset state and quiet idle line
    rstB = 1'b0;
    repeat (3) @(negedge clk);
    check(txW == 3'b111, "reset tx", int'(txW), 7);
    check(busyW == 3'b000, "reset busy", int'(busyW), 0);
    check(rdEnW == 3'b000, "reset FfRdEn", int'(rdEnW), 0);
    #2 rstB = 1'b1;
    ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (txW != 3'b111 || busyW != 3'b000 || rdEnW != 3'b000) ok = 1'b0;
    end
    check(ok, "idle with empty FIFO", int'(ok), 1);

    // Single bytes, MSB-first unit, and back-to-back frames with two stop bits
    @(negedge clk);
    pushByte(0, 8'hA5);
    pushByte(1, 8'h01);
    pushByte(2, 8'h3C);
    pushByte(2, 8'h81);
    n = 0;
    while (!doneW[0] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(n < 400, "unit0 txDone seen", n, 400);
    @(negedge clk);
    check(busyW[0] == 1'b0, "unit0 busy after txDone", int'(busyW[0]), 0);
    waitIdle(1000);
    check(rdEnCnt[0] == 1, "unit0 read strobes", rdEnCnt[0], 1);
    check(rdEnCnt[1] == 1, "unit1 read strobes", rdEnCnt[1], 1);
    check(rdEnCnt[2] == 2, "unit2 read strobes", rdEnCnt[2], 2);
    check(rdEnTime[2][1] - rdEnTime[2][0] == 11 * BC + 2, "unit2 frame period",
          rdEnTime[2][1] - rdEnTime[2][0], 11 * BC + 2);

    // Three queued bytes stream with the minimum frame period
    base = rdEnCnt[0];
    pushByte(0, 8'h00);
    pushByte(0, 8'hFF);
    pushByte(0, 8'h55);
    waitIdle(1000);
    check(rdEnCnt[0] - base == 3, "unit0 burst read strobes", rdEnCnt[0] - base, 3);
    for (int k = 0; k < 2; k++)
      check(rdEnTime[0][base+k+1] - rdEnTime[0][base+k] == 10 * BC + 2,
            $sformatf("unit0 burst period %0d", k),
            rdEnTime[0][base+k+1] - rdEnTime[0][base+k], 10 * BC + 2);

    // Randomized traffic on all units
    for (int r = 0; r < 4; r++) begin
      for (int u = 0; u < NU; u++) begin
        int cnt = int'($urandom_range(0, 3));
        for (int j = 0; j < cnt; j++) pushByte(u, 8'($urandom));
      end
      waitIdle(3000);
    end

    // Reset in the middle of data bit 4 aborts the frame
    base = rdEnCnt[0];
    pushByte(0, 8'h2C);
    repeat (90) @(negedge clk);
    check(txW[0] == 1'b0, "unit0 data bit4 before reset", int'(txW[0]), 0);
    #1 rstB = 1'b0;
    #1;
    check(txW[0] == 1'b1, "tx high at reset assertion", int'(txW[0]), 1);
    check(busyW == 3'b000, "busy low at reset assertion", int'(busyW), 0);
    repeat (3) @(negedge clk);
    #2 rstB = 1'b1;
    ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (txW != 3'b111 || rdEnW != 3'b000) ok = 1'b0;
    end
    check(ok, "idle after mid-frame reset", int'(ok), 1);
    check(rdEnCnt[0] - base == 1, "no read after mid-frame reset", rdEnCnt[0] - base, 1);

    for (int u = 0; u < NU; u++)
      check(expRd[u] == expWr[u], $sformatf("unit%0d frames observed", u), expRd[u], expWr[u]);
  endtask

  initial begin
    rstB = 1'b0;
    fork
      begin
        forever begin
          @(negedge clk);
          monStep();
        end
      end
      begin
        runStim();
      end
      begin
        #300000;
        check(1'b0, "global time limit", cycleNum, 30000);
      end
    join_any
    disable fork;
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
